fuzzy_seq_ctrl: RTL
===================

# fuzzy_seq_ctrl

Front-end sequencer for the fuzzy risk engine. Collects operand bytes strobed in on the shared 8-bit data bus by the `ss` pin, presents them to the engine, fires a start pulse, waits for completion with a timeout, and holds the resulting risk byte on the output pins. It sits between the pad-level wrapper (`ui_in`, `uio_in[0]`, `uo_out`) and the fuzzification/inference/defuzzification datapath.

## Interface
Parameters:
- `NUM_IN`, 3: operand bytes per frame (crisp inputs to the engine), ≥1.
- `DW`, 8: operand and risk width.
- `TIMEOUT`, 255: maximum WAIT cycles before abort, 1..255.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ss_i` in 1: asynchronous byte strobe from the pad; a rising edge captures one byte.
- `data_i` in DW: operand byte from the data bus.
- `eng_in_o` out NUM_IN*DW: operand vector; byte 0 in [DW-1:0].
- `eng_start_o` out 1: one-cycle start pulse to the engine.
- `eng_done_i` in 1: engine completion, level or pulse, sampled only in WAIT.
- `eng_risk_i` in DW: engine result, valid while `eng_done_i`=1.
- `risk_o` out DW: last good risk value, held.
- `valid_o` out 1: `risk_o` holds a result for the latest completed frame.
- `busy_o` out 1: high in START and WAIT.
- `err_o` out 1: sticky error for the current frame (timeout or checksum).

## Operation
- `ss_i` goes through a 2-flop synchronizer plus rising-edge detector; the edge pulse `cap` samples `data_i` directly. The host must hold `data_i` stable from ss rise until 4 cycles after it.
- FSM states: IDLE, LOAD, START, WAIT.
- IDLE: on `cap`, store byte 0, clear `valid_o` and `err_o`, set index=1, go LOAD (go START directly if NUM_IN=1).
- LOAD: on `cap`, store byte[index], index++; after byte NUM_IN-1 go START.
- START: `eng_start_o`=1 for exactly one cycle, clear timeout counter, go WAIT.
- WAIT: if `eng_done_i`, latch `risk_o`←`eng_risk_i`, set `valid_o`, go IDLE. Otherwise counter++; when counter reaches TIMEOUT, set `err_o`, leave `risk_o` and `valid_o`=0 unchanged, and go IDLE.
- `cap` in START or WAIT is ignored and the byte is dropped.
- `eng_in_o` stays stable from START until the next frame's first capture.
- Counter width: 8 bits; saturating comparison, no wrap.
- Reset at any point: state=IDLE, index=0, counter=0, `eng_in_o`=0, `risk_o`=0, `valid_o`=0, `err_o`=0, `eng_start_o`=0, `busy_o`=0, synchronizer flops=0. A frame in flight is discarded. An engine done that arrives after reset is ignored.

## Timing
- ss rise → `cap`: 3 clk cycles (2 sync + edge register). Minimum ss high and low times: 3 cycles each.
- Last `cap` → `eng_start_o` high: 1 cycle.
- `eng_done_i` sampled high in WAIT → `risk_o`/`valid_o` updated on the next edge.
- Done and timeout in the same cycle: done wins, with no error.
- Throughput: a new frame may begin the cycle after returning to IDLE.

## Configuration
- `FUZZ_CKSUM_EN` defined: each frame is NUM_IN+1 bytes. The extra last byte must equal the 8-bit sum (mod 256) of the operand bytes. On a match, go START. On a mismatch, set `err_o`, do not start, return to IDLE, and keep `eng_in_o` at the previous frame's operands (hold operands in a staging register until the check passes).
- Not defined: frame is NUM_IN bytes, with no check and no staging register. `err_o` flags timeout only.

## Structure
- Package `fuzz_ctrl_pkg`: FSM state enum, `FUZZ_DW`=8, `FUZZ_NUM_IN_DEF`=3, `FUZZ_TIMEOUT_DEF`=255.
- Sub-module `ss_sync_edge`: 2-flop synchronizer and rising-edge pulse, with async active-high reset.

## Test plan
- Reset, then strobe 0x10, 0x20, 0x30 → one `eng_start_o` pulse 1 cycle after the third `cap`, `eng_in_o`=0x302010; engine returns done with 0xA5 → `risk_o`=0xA5, `valid_o`=1, `err_o`=0.
- Same frame, engine never asserts done → `err_o`=1 exactly TIMEOUT cycles after START, `risk_o` keeps its prior value, FSM back in IDLE.
- Extra ss strobes during WAIT → no capture, index unchanged; next frame's bytes land in slots 0..2 correctly.
- Assert `rst` mid-LOAD after 2 bytes → all outputs 0 asynchronously; a new 3-byte frame then starts cleanly.
- With `FUZZ_CKSUM_EN`, bytes 0x10, 0x20, 0x30, 0x60 → start issued; bytes 0x10, 0x20, 0x30, 0x61 → `err_o`=1, no start, `eng_in_o` unchanged.
- Done and timeout coincide (done at cycle TIMEOUT) → `valid_o`=1, `err_o`=0.

Source files
------------

// File: rtl/fuzz_ctrl_pkg.sv
// Shared definitions for the fuzzy risk engine front-end sequencer.
package fuzz_ctrl_pkg;

    localparam int unsigned FUZZ_DW          = 8;
    localparam int unsigned FUZZ_NUM_IN_DEF  = 3;
    localparam int unsigned FUZZ_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/ss_sync_edge.sv
// Two-flop synchronizer for the pad byte strobe plus a registered rising-edge pulse.
module ss_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ss,
    output logic cap
);
    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            cap  <= 1'b0;
        end else begin
            meta <= ss;
            sync <= meta;
            prev <= sync;
            cap  <= sync & ~prev;
        end
    end
endmodule

// File: rtl/fuzzy_seq_ctrl.sv
// Front-end sequencer: strobed operand capture, engine start/wait handshake with timeout.
// Optional FUZZ_CKSUM_EN: trailing checksum byte per frame, operands staged until it matches.
module fuzzy_seq_ctrl
    import fuzz_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IN  = FUZZ_NUM_IN_DEF,
    parameter int unsigned DW      = FUZZ_DW,
    parameter int unsigned TIMEOUT = FUZZ_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_i,
    input  logic [DW-1:0]        data_i,
    output logic [NUM_IN*DW-1:0] eng_in_o,
    output logic                 eng_start_o,
    input  logic                 eng_done_i,
    input  logic [DW-1:0]        eng_risk_i,
    output logic [DW-1:0]        risk_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 err_o
);
`ifdef FUZZ_CKSUM_EN
    localparam int unsigned LAST = NUM_IN;
`else
    localparam int unsigned LAST = NUM_IN - 1;
`endif
    localparam int unsigned   IW       = $clog2(NUM_IN + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(LAST);
    localparam logic [7:0]    CNT_MAX  = 8'(TIMEOUT - 1);

    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [7:0]           cnt, cnt_n;
    logic [NUM_IN*DW-1:0] ops, ops_n;
    logic [DW-1:0]        risk, risk_n;
    logic                 valid, valid_n;
    logic                 err, err_n;
    logic                 cap;

`ifdef FUZZ_CKSUM_EN
    logic [NUM_IN*DW-1:0] stg, stg_n;
    logic [DW-1:0]        sum;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            sum = sum + stg[i*DW +: DW];
        end
    end
`endif

    ss_sync_edge u_sync (
        .clk (clk),
        .rst (rst),
        .ss  (ss_i),
        .cap (cap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
            ops   <= '0;
            risk  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
`ifdef FUZZ_CKSUM_EN
            stg   <= '0;
`endif
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            ops   <= ops_n;
            risk  <= risk_n;
            valid <= valid_n;
            err   <= err_n;
`ifdef FUZZ_CKSUM_EN
            stg   <= stg_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        ops_n   = ops;
        risk_n  = risk;
        valid_n = valid;
        err_n   = err;
`ifdef FUZZ_CKSUM_EN
        stg_n   = stg;
`endif
        unique case (state)
            S_IDLE: begin
                if (cap) begin
`ifdef FUZZ_CKSUM_EN
                    stg_n[DW-1:0] = data_i;
`else
                    ops_n[DW-1:0] = data_i;
`endif
                    valid_n = 1'b0;
                    err_n   = 1'b0;
                    idx_n   = IW'(1);
                    state_n = (LAST == 0) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                if (cap) begin
`ifdef FUZZ_CKSUM_EN
                    // The trailing byte is the checksum; operands are published only on a match.
                    if (idx == LAST_IDX) begin
                        if (data_i == sum) begin
                            ops_n   = stg;
                            state_n = S_START;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        stg_n[int'(idx)*DW +: DW] = data_i;
                        idx_n = idx + 1'b1;
                    end
`else
                    ops_n[int'(idx)*DW +: DW] = data_i;
                    idx_n = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = S_START;
                    end
`endif
                end
            end
            S_START: begin
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // Done has priority over the timeout in the same cycle.
                if (eng_done_i) begin
                    risk_n  = eng_risk_i;
                    valid_n = 1'b1;
                    state_n = S_IDLE;
                end else if (cnt >= CNT_MAX) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign eng_in_o    = ops;
    assign risk_o      = risk;
    assign valid_o     = valid;
    assign err_o       = err;
    assign eng_start_o = (state == S_START);
    assign busy_o      = (state == S_START) || (state == S_WAIT);
endmodule
